bcminer_multilane_collector: RTL and testbench

- Parametrised result-collection stage for the next-generation miner: gathers per-cycle results from NUM_LANES independent lattice chains instead of a single chain.
- Reconstructs the full 32-bit nonce of each winning hash.
- Arbitrates simultaneous winners round-robin and buffers them in a FIFO for the host nonce reader.
- Drives a real sticky overflow instead of a constant 0.

---
 rtl/bcminer_multilane_collector.sv | 214 +++++++++++++++++++++
 tb/tb_bcminer_multilane_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcminer_multilane_collector.sv
// bcminer_multilane_collector: gathers per-cycle results from NUM_LANES lattice
// chains. It rebuilds each winner's nonce as {lane counter, lane index}, parks
// winners in one pending slot per lane and arbitrates them round-robin into a
// first-word-fall-through FIFO for the host.
// Optional feature macro: BCMINER_STATS_EN adds the stat_wins/stat_drops counters.
//
// Host handshake: nonce_valid is high whenever the FIFO holds an entry, and
// nonce_out then shows the head. Asserting rd_en while nonce_valid is high
// consumes the head at that clock edge. rd_en while nonce_valid is low is ignored.
module bcminer_multilane_collector #(
  parameter int NUM_LANES  = 4,
  parameter int LANEBITS   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          block_start,
  input  logic [NUM_LANES-1:0]          lane_valid,
  input  logic [NUM_LANES-1:0]          lane_success,
  input  logic                          rd_en,
  output logic [NONCE_W-1:0]            nonce_out,
  output logic                          nonce_valid,
  output logic                          overflow,
  output logic                          exhausted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef BCMINER_STATS_EN
  ,
  output logic [15:0]                   stat_wins,
  output logic [15:0]                   stat_drops
`endif
);

  localparam int CNT_W = NONCE_W - LANEBITS;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [LANEBITS-1:0] PTR_ONE   = LANEBITS'(1);
  localparam logic [LANEBITS-1:0] LAST_LANE = LANEBITS'(NUM_LANES - 1);
  localparam logic [AW-1:0]       AW_ONE    = AW'(1);
  localparam logic [LW-1:0]       LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]       FULL_LVL  = LW'(FIFO_DEPTH);

  logic [CNT_W-1:0]    cnt_q [NUM_LANES];
  logic [CNT_W-1:0]    cnt_d [NUM_LANES];
  logic [NONCE_W-1:0]  pend_q [NUM_LANES];
  logic [NONCE_W-1:0]  pend_d [NUM_LANES];
  logic [NUM_LANES-1:0] done_q, done_d;
  logic [NUM_LANES-1:0] pend_v_q, pend_v_d;
  logic [NUM_LANES-1:0] acc, win, drop, capt;
  logic [LANEBITS-1:0] rr_q, rr_d;
  logic [LANEBITS-1:0] gnt_idx;
  logic                gnt_found;
  logic                ovf_q, exh_q;

  logic [NONCE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic                full, push, pop;

  // A lane result counts only if the lane has not swept its space and the
  // cycle does not belong to the outgoing block.
  assign acc = lane_valid & ~done_q & {NUM_LANES{~block_start}};
  assign win = acc & lane_success;

  // Round-robin search over pending slots starting at the pointer.
  always_comb begin
    logic [LANEBITS-1:0] idx;
    idx       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = rr_q + LANEBITS'(i);
      if (!gnt_found && pend_v_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // A full FIFO still accepts a push when the host pops in the same cycle.
  assign full = (lvl_q == FULL_LVL);
  assign pop  = rd_en & (lvl_q != '0) & ~block_start;
  assign push = gnt_found & ~block_start & (~full | rd_en);

  // Per-lane counters, sweep tracking and pending-slot capture or drop.
  always_comb begin
    cnt_d    = cnt_q;
    done_d   = done_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    drop     = '0;
    capt     = '0;
    rr_d     = rr_q;
    if (push) rr_d = (gnt_idx == LAST_LANE) ? '0 : gnt_idx + PTR_ONE;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (block_start) begin
        cnt_d[l]    = '0;
        done_d[l]   = 1'b0;
        pend_v_d[l] = 1'b0;
      end else begin
        if (acc[l]) begin
          cnt_d[l] = cnt_q[l] + CNT_ONE;
          if (&cnt_q[l]) done_d[l] = 1'b1;
        end
        if (win[l]) begin
          if (pend_v_q[l] && !(push && gnt_idx == LANEBITS'(l))) begin
            drop[l] = 1'b1;
          end else begin
            capt[l]     = 1'b1;
            pend_d[l]   = {cnt_q[l], LANEBITS'(l)};
            pend_v_d[l] = 1'b1;
          end
        end else if (push && gnt_idx == LANEBITS'(l)) begin
          pend_v_d[l] = 1'b0;
        end
      end
    end
  end

  // Lane state, arbiter pointer, sticky overflow and exhaustion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        cnt_q[l]  <= '0;
        pend_q[l] <= '0;
      end
      done_q   <= '0;
      pend_v_q <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
      exh_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      pend_v_q <= pend_v_d;
      rr_q     <= rr_d;
      ovf_q    <= block_start ? 1'b0 : (ovf_q | (|drop));
      exh_q    <= &done_d;
    end
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    lvl_d = lvl_q;
    if (push && !pop)      lvl_d = lvl_q + LVL_ONE;
    else if (!push && pop) lvl_d = lvl_q - LVL_ONE;
  end

  // FIFO pointers and occupancy; block_start empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (block_start) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW_ONE;
      if (pop)  rd_q <= rd_q + AW_ONE;
      lvl_q <= lvl_d;
    end
  end

  // FIFO storage; contents are only observable through the gated head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pend_q[gnt_idx];
  end

  assign nonce_valid = (lvl_q != '0);
  assign nonce_out   = nonce_valid ? mem_q[rd_q] : '0;
  assign fifo_level  = lvl_q;
  assign overflow    = ovf_q;
  assign exhausted   = exh_q;

`ifdef BCMINER_STATS_EN
  logic [15:0] wins_q, drops_q;
  logic [16:0] wins_sum, drops_sum;
  int          n_capt, n_drop;

  // Count captured and dropped winners this cycle, saturating at 16 bits.
  always_comb begin
    n_capt = 0;
    n_drop = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      n_capt = n_capt + int'(capt[l]);
      n_drop = n_drop + int'(drop[l]);
    end
    wins_sum  = {1'b0, wins_q} + 17'(n_capt);
    drops_sum = {1'b0, drops_q} + 17'(n_drop);
  end

  // Statistics registers, cleared with the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wins_q  <= '0;
      drops_q <= '0;
    end else if (block_start) begin
      wins_q  <= '0;
      drops_q <= '0;
    end else begin
      wins_q  <= wins_sum[16] ? 16'hFFFF : wins_sum[15:0];
      drops_q <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end
  end

  assign stat_wins  = wins_q;
  assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_bcminer_multilane_collector.sv
// Directed bench for bcminer_multilane_collector with NUM_LANES=4, NONCE_W=8
// (6-bit lane counters so exhaustion is reachable) and FIFO_DEPTH=8.
// Expected nonces are queued when winners are issued; a monitor compares the
// head whenever the host pops.
module tb_bcminer_multilane_collector;
  localparam int NL = 4;
  localparam int NW = 8;
  localparam int FD = 8;

  logic          clk;
  logic          rst_n;
  logic          block_start;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_success;
  logic          rd_en;
  logic [NW-1:0] nonce_out;
  logic          nonce_valid;
  logic          overflow;
  logic          exhausted;
  logic [3:0]    fifo_level;
`ifdef BCMINER_STATS_EN
  logic [15:0]   stat_wins;
  logic [15:0]   stat_drops;
`endif

  int vectors;
  int miscompares;
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] mon_exp;

  bcminer_multilane_collector #(
    .NUM_LANES (NL),
    .NONCE_W   (NW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .block_start (block_start),
    .lane_valid  (lane_valid),
    .lane_success(lane_success),
    .rd_en       (rd_en),
    .nonce_out   (nonce_out),
    .nonce_valid (nonce_valid),
    .overflow    (overflow),
    .exhausted   (exhausted),
    .fifo_level  (fifo_level)
`ifdef BCMINER_STATS_EN
    ,
    .stat_wins   (stat_wins),
    .stat_drops  (stat_drops)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, return 1ns after the sampling edge.
  task automatic drive(input logic [NL-1:0] v, input logic [NL-1:0] s,
                       input logic rd, input logic bs);
    lane_valid   = v;
    lane_success = s;
    rd_en        = rd;
    block_start  = bs;
    @(posedge clk);
    #1;
    lane_valid   = '0;
    lane_success = '0;
    rd_en        = 1'b0;
    block_start  = 1'b0;
  endtask

  // Scoreboard monitor: compare the head on every accepted pop.
  always @(negedge clk) begin
    if (rst_n && rd_en && nonce_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got %0h expected no entry", nonce_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (nonce_out !== mon_exp) begin
          miscompares++;
          $display("FAIL pop_nonce: got %0h expected %0h", nonce_out, mon_exp);
        end
      end
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    block_start  = 1'b0;
    lane_valid   = '0;
    lane_success = '0;
    rd_en        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nonce_out", nonce_out, 8'h00);
    check("rst_nonce_valid", nonce_valid, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_exhausted", exhausted, 1'b0);
    rst_n = 1'b1;
    drive('0, '0, 1'b0, 1'b0);

    // Lanes 0,1,3 win together with the pointer at 0: order 0,1,3.
    drive(4'b1011, 4'b1011, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    check("rr_pending_only", fifo_level, 4'd0);
    drive('0, '0, 1'b0, 1'b0);
    check("rr_level1", fifo_level, 4'd1);
    check("rr_head", nonce_out, 8'h00);
    drive('0, '0, 1'b0, 1'b0);
    check("rr_level2", fifo_level, 4'd2);
    drive('0, '0, 1'b0, 1'b0);
    check("rr_level3", fifo_level, 4'd3);
    check("rr_no_overflow", overflow, 1'b0);
    repeat (3) drive('0, '0, 1'b1, 1'b0);
    check("rr_drained", fifo_level, 4'd0);

    // Lane 2: five plain results, then a win at counter 5 -> nonce 0x16.
    repeat (5) drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0, 1'b0);
    exp_q.push_back(8'h16);
    check("lat_not_yet", nonce_valid, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("lat_valid", nonce_valid, 1'b1);
    check("lat_nonce", nonce_out, 8'h16);
    check("lat_level", fifo_level, 4'd1);
    drive('0, '0, 1'b1, 1'b0);
    check("lat_drained", fifo_level, 4'd0);

    // Lane 0 wins 10 cycles running (counter 1..10); FIFO fills, 10th dropped.
    for (int c = 1; c <= 10; c++) begin
      drive(4'b0001, 4'b0001, 1'b0, 1'b0);
      if (c <= 9) exp_q.push_back(NW'(c * 4));
      if (c == 9) begin
        check("fill_level", fifo_level, 4'd8);
        check("fill_no_ovf", overflow, 1'b0);
      end
    end
    check("drop_level", fifo_level, 4'd8);
    check("drop_overflow", overflow, 1'b1);
    check("full_head", nonce_out, 8'h04);
    drive('0, '0, 1'b1, 1'b0);
    check("full_pushpop_level", fifo_level, 4'd8);
    drive('0, '0, 1'b0, 1'b0);
    check("full_idle_level", fifo_level, 4'd8);

    // Drain to 3 entries, then block_start with a same-cycle win discarded.
    repeat (5) drive('0, '0, 1'b1, 1'b0);
    check("bs_pre_level", fifo_level, 4'd3);
    check("bs_pre_ovf", overflow, 1'b1);
    drive(4'b0010, 4'b0010, 1'b0, 1'b1);
    exp_q.delete();
    check("bs_level", fifo_level, 4'd0);
    check("bs_overflow", overflow, 1'b0);
    check("bs_valid", nonce_valid, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("bs_discard", fifo_level, 4'd0);
    drive(4'b0010, 4'b0010, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
    drive('0, '0, 1'b0, 1'b0);
    check("bs_restart_nonce", nonce_out, 8'h01);
    check("bs_restart_level", fifo_level, 4'd1);
    drive('0, '0, 1'b1, 1'b0);

    // Sweep all 64 counter values on every lane; lane 0 wins at 63 -> 0xFC.
    drive('0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) drive(4'b1111, 4'b0001, 1'b0, 1'b0);
      else         drive(4'b1111, 4'b0000, 1'b0, 1'b0);
      if (i == 63) check("exh_not_yet", exhausted, 1'b0);
    end
    exp_q.push_back(8'hFC);
    check("exh_set", exhausted, 1'b1);
    repeat (3) drive(4'b1111, 4'b1111, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("exh_no_push", fifo_level, 4'd1);
    check("exh_held", exhausted, 1'b1);
    check("exh_no_ovf", overflow, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    check("exh_drained", fifo_level, 4'd0);
    drive('0, '0, 1'b0, 1'b1);
    check("exh_cleared", exhausted, 1'b0);

    // Fill the FIFO, then reset between clock edges.
    for (int c = 0; c < 8; c++) drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    check("arst_pre_level", fifo_level, 4'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", nonce_valid, 1'b0);
    check("arst_level", fifo_level, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
